// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee-maker datapath: amount width, coin
// denominations and the change-dispenser state encoding.
package coffee_pkg;

  localparam int AMT_W_DEFAULT = 4;

  localparam int COIN_HI_UNITS = 5;
  localparam int COIN_LO_UNITS = 1;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_PULSE,
    DISP_GAP,
    DISP_DONE
  } disp_state_t;

  function automatic int coin_units(input logic hi);
    return hi ? COIN_HI_UNITS : COIN_LO_UNITS;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Reloadable down-counter; expire marks the last cycle of a loaded interval
// (a load of N-1 yields an interval of N cycles).
module pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin ejector sequencer: dispenses the latched change as 500-colon coins
// first, then 100-colon coins, one timed solenoid pulse per coin.
module change_dispenser
  import coffee_pkg::*;
#(
  parameter int PULSE_CYCLES = 10_000_000,
  parameter int GAP_CYCLES   = 10_000_000,
  parameter int AMT_W        = AMT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] cambio,
  output logic             coin500,
  output logic             coin100,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             done
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  disp_state_t      state, state_d;
  logic [AMT_W-1:0] amt, amt_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             expire;
  logic             hi_sel;
  logic             coin500_d, coin100_d;

  pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .expire  (expire)
  );

  // Coin drives are registered from the next state so they rise together
  // with PULSE entry and drop asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= DISP_IDLE;
      amt     <= '0;
      coin500 <= 1'b0;
      coin100 <= 1'b0;
    end else begin
      state   <= state_d;
      amt     <= amt_d;
      coin500 <= coin500_d;
      coin100 <= coin100_d;
    end
  end

  always_comb begin
    state_d  = state;
    amt_d    = amt;
    load     = 1'b0;
    load_val = PULSE_LOAD;
    case (state)
      DISP_IDLE: begin
        if (start) begin
          amt_d = cambio;
          if (cambio != '0) begin
            state_d = DISP_PULSE;
            load    = 1'b1;
          end else begin
            state_d = DISP_DONE;
          end
        end
      end
      DISP_PULSE: begin
        if (expire) begin
          state_d  = DISP_GAP;
          amt_d    = amt - AMT_W'(coin_units(coin500));
          load     = 1'b1;
          load_val = GAP_LOAD;
        end
      end
      DISP_GAP: begin
        if (expire) begin
          if (amt != '0) begin
            state_d = DISP_PULSE;
            load    = 1'b1;
          end else begin
            state_d = DISP_DONE;
          end
        end
      end
      DISP_DONE: state_d = DISP_IDLE;
      default:   state_d = DISP_IDLE;
    endcase
  end

  // Denomination is fixed on PULSE entry and held until the pulse ends.
  always_comb begin
    if (state == DISP_PULSE) begin
      hi_sel = coin500;
    end else begin
      hi_sel = (32'(amt_d) >= 32'(COIN_HI_UNITS));
    end
    coin500_d = (state_d == DISP_PULSE) && hi_sel;
    coin100_d = (state_d == DISP_PULSE) && !hi_sel;
    busy      = (state != DISP_IDLE);
    done      = (state == DISP_DONE);
    remaining = amt;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized bench for change_dispenser against a per-cycle
// timeline model derived from the coin-count and timing rules.
module tb_change_dispenser;

  localparam int P = 4;
  localparam int G = 2;
  localparam int C = P + G;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] cambio = '0;
  logic         coin500, coin100, busy, done;
  logic [W-1:0] remaining;

  int total = 0;
  int bad   = 0;

  change_dispenser #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .AMT_W       (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cambio   (cambio),
    .coin500  (coin500),
    .coin100  (coin100),
    .remaining(remaining),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int txn_len(input int a);
    return (a / 5 + a % 5) * C + 1;
  endfunction

  // Expected outputs in cycle k+t for a transaction of amount a accepted at edge k.
  task automatic model(input int a, input int t, output logic e500, output logic e100,
                       output logic eb, output logic ed, output int erem);
    int n_hi, tl, idx, ph;
    n_hi = a / 5;
    tl   = txn_len(a);
    e500 = 1'b0; e100 = 1'b0; eb = 1'b0; ed = 1'b0; erem = 0;
    if (t >= 1 && t < tl) begin
      eb  = 1'b1;
      idx = (t - 1) / C;
      ph  = (t - 1) % C;
      if (ph < P) begin
        if (idx < n_hi) e500 = 1'b1;
        else            e100 = 1'b1;
      end
      erem = a;
      for (int j = 0; j <= idx; j++) begin
        if (j < idx || ph >= P) erem -= (j < n_hi) ? 5 : 1;
      end
    end else if (t == tl) begin
      eb = 1'b1;
      ed = 1'b1;
    end
  endtask

  task automatic check_cycle(input int a, input int t, input string tag);
    logic e500, e100, eb, ed;
    int   erem;
    model(a, t, e500, e100, eb, ed, erem);
    check($sformatf("%s t=%0d coin500", tag, t), 32'(coin500), 32'(e500));
    check($sformatf("%s t=%0d coin100", tag, t), 32'(coin100), 32'(e100));
    check($sformatf("%s t=%0d busy", tag, t), 32'(busy), 32'(eb));
    check($sformatf("%s t=%0d done", tag, t), 32'(done), 32'(ed));
    check($sformatf("%s t=%0d remaining", tag, t), 32'(remaining), 32'(erem));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " coin500"}, 32'(coin500), 32'd0);
    check({tag, " coin100"}, 32'(coin100), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " remaining"}, 32'(remaining), 32'd0);
  endtask

  // Called at a negedge in an IDLE cycle; issues start and follows the whole
  // transaction. With chain set it returns in the first IDLE cycle after done.
  task automatic txn(input int a, input int inj_t, input int inj_a, input bit chain,
                     input string tag);
    int tl;
    tl     = txn_len(a);
    start  = 1'b1;
    cambio = W'(a);
    @(negedge clk);
    for (int t = 1; t <= tl + 1; t++) begin
      check_cycle(a, t, tag);
      start = 1'b0;
      if (t < tl) cambio = W'($urandom);
      if (t == inj_t) begin
        start  = 1'b1;
        cambio = W'(inj_a);
      end
      if (!(t == tl + 1 && chain)) @(negedge clk);
    end
  endtask

  initial begin
    int a;
    bit chain;

    #1 reset = 1'b0;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    txn(7, -1, 0, 1'b0, "amt7");
    txn(0, -1, 0, 1'b0, "amt0");
    txn(15, -1, 0, 1'b0, "amt15");
    txn(3, 5, 9, 1'b0, "amt3_busy_start");

    start  = 1'b1;
    cambio = W'(5);
    @(negedge clk);
    start = 1'b0;
    check_cycle(5, 1, "rst_mid");
    @(negedge clk);
    check_cycle(5, 2, "rst_mid");
    #1 reset = 1'b0;
    #1 check_zero("rst_mid_async");
    @(negedge clk);
    check_zero("rst_mid_hold");
    reset = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_release");
    txn(1, -1, 0, 1'b0, "after_rst");

    txn(6, -1, 0, 1'b1, "b2b_a");
    txn(2, -1, 0, 1'b1, "b2b_b");
    txn(0, -1, 0, 1'b1, "b2b_c");
    txn(5, -1, 0, 1'b0, "b2b_d");

    for (int i = 0; i < 12; i++) begin
      a     = int'($urandom_range(0, 15));
      chain = 1'($urandom_range(0, 1));
      txn(a, -1, 0, chain, $sformatf("rnd%0d_a%0d", i, a));
      if (!chain) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    check_zero("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
